instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Fetch stage directly downstream of the program counter register.
- Takes the current PC, issues single-outstanding instruction-memory reads over a valid/ready request channel, and buffers returned words with their PC in a small FIFO for decode.
- Produces a one-cycle `pc_accept` pulse that the next-PC logic uses to advance `pcin`, and supports pipeline flush with squash of an in-flight read.

Parameters:
- XLEN, 32, width of PC and instruction word.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, ≥2.
- NOP_WORD, 32'h00000013, instruction substituted on a faulting fetch.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous reset, active-low (reset==0 resets; deassertion is synchronous to clk).
- pc_in  input  XLEN  current PC from the program counter register.
- pc_accept  output  1  one-cycle pulse: the request for pc_in was accepted by memory, so upstream may advance.
- flush  input  1  discard buffered and in-flight fetches (branch/trap redirect).
- imem_req_valid  output  1  read request valid.
- imem_req_ready  input  1  memory accepts the request.
- imem_req_addr  output  XLEN  request address.
- imem_rsp_valid  input  1  response valid; exactly one per accepted request, no backpressure.
- imem_rsp_data  input  XLEN  read data.
- imem_rsp_err  input  1  bus error on this response.
- if_valid  output  1  buffered instruction available.
- if_ready  input  1  decode consumes the head entry.
- if_instr  output  XLEN  head instruction.
- if_pc  output  XLEN  PC of the head instruction.
- if_fault  output  1  head entry came from an error response.

Behaviour:
- Reset (reset==0, async):
  - State IDLE, FIFO empty, squash=0, req_pc=0.
  - `imem_req_valid`, `pc_accept`, `if_valid`, `if_fault`=0; `imem_req_addr`, `if_instr`, `if_pc`=0.
- States: IDLE, REQ, WAIT.
- IDLE: if !flush and count<FIFO_DEPTH, latch req_pc<=pc_in and go to REQ. Otherwise stay.
- REQ:
  - `imem_req_valid`=1 and `imem_req_addr`=req_pc (registered; stable while waiting).
  - Valid is never retracted before `imem_req_ready`.
  - On req_valid&&req_ready: go to WAIT; `pc_accept`=1 that cycle unless squash or flush is 1.
- WAIT: on `imem_rsp_valid`:
  - If squash or flush: discard the response, clear squash, go to IDLE.
  - Else enqueue {req_pc, err ? NOP_WORD : data, err}.
  - If count_next<FIFO_DEPTH, latch req_pc<=pc_in and go directly to REQ (back-to-back). Otherwise go to IDLE.
- count_next = count + enqueue - dequeue. A slot is reserved at issue, so enqueue never overflows.
- flush:
  - FIFO cleared next cycle (count=0).
  - In REQ or WAIT, squash<=1; the outstanding request still completes its handshake and response, then is dropped.
  - In IDLE, no request is issued that cycle.
  - Flush takes priority over enqueue and dequeue in the same cycle.
- Decode side:
  - `if_valid` = (count!=0); if_instr/if_pc/if_fault show the head entry combinationally from the buffer.
  - Dequeue on if_valid&&if_ready.
  - Enqueue and dequeue may occur in the same cycle.
- Latency: request issue to earliest `if_valid` is 1 cycle after `imem_rsp_valid`. Peak throughput is one instruction per 2 cycles with a 0-wait memory (REQ→WAIT→REQ).
- Pointers wrap modulo FIFO_DEPTH; the count register is $clog2(FIFO_DEPTH)+1 bits.
- Reset asserted mid-transaction: all state is cleared immediately. Memory is assumed reset by the same signal, so a late response is not expected.

Test Plan:
- Reset release, pc_in=0x0, req_ready=1, rsp 1 cycle later with data 0x00500093 → req_addr=0x0, pc_accept pulse, if_valid=1 with if_instr=0x00500093, if_pc=0x0.
- if_ready=0, pc_in stepping 0x0/0x4/0x8 → exactly 2 entries buffered (0x0, 0x4); no request for 0x8 until one dequeue, then req_addr=0x8.
- req_ready held low 3 cycles → req_valid and req_addr=0x10 stay stable, pc_accept pulses only in the accept cycle.
- Flush asserted while in WAIT with 1 entry buffered → FIFO empty next cycle, the subsequent response is dropped (if_valid stays 0), and the next request uses the new pc_in=0x100.
- imem_rsp_err=1 for pc 0x20 → entry if_instr=0x00000013, if_fault=1, if_pc=0x20.
- reset pulled low during REQ → imem_req_valid=0 and if_valid=0 immediately (before the next clk edge).

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one outstanding imem read at a time and
// buffers each returned word with its PC in a small FIFO for decode.
module instr_fetch #(
  parameter int              XLEN       = 32,
  parameter int              FIFO_DEPTH = 2,
  parameter logic [XLEN-1:0] NOP_WORD   = XLEN'(32'h00000013)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_accept,
  input  logic            flush,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            if_fault,
  output logic [1:0]      o_dbg_state
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic            r_squash;
  logic [XLEN-1:0] r_req_pc;

  logic [XLEN-1:0] r_buf_pc    [FIFO_DEPTH];
  logic [XLEN-1:0] r_buf_instr [FIFO_DEPTH];
  logic            r_buf_fault [FIFO_DEPTH];

  logic            w_hs;
  logic            w_enq;
  logic            w_deq;
  logic [CW-1:0]   w_count_next;

  // Request channel: valid/ready, a transfer happens on the cycle both are high;
  // valid and address hold steady from assertion until that cycle.
  assign w_hs         = (r_state == S_REQ) && imem_req_ready;
  assign w_enq        = (r_state == S_WAIT) && imem_rsp_valid && !r_squash && !flush;
  assign w_deq        = if_valid && if_ready && !flush;
  assign w_count_next = r_count + CW'(w_enq) - CW'(w_deq);

  assign imem_req_valid = (r_state == S_REQ);
  assign imem_req_addr  = r_req_pc;
  assign pc_accept      = w_hs && !r_squash && !flush;
  assign o_dbg_state    = r_state;

  assign if_valid = (r_count != '0);
  assign if_instr = if_valid ? r_buf_instr[r_rd_ptr] : '0;
  assign if_pc    = if_valid ? r_buf_pc[r_rd_ptr]    : '0;
  assign if_fault = if_valid ? r_buf_fault[r_rd_ptr] : 1'b0;

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_buf_pc[r_wr_ptr]    <= r_req_pc;
      r_buf_instr[r_wr_ptr] <= imem_rsp_err ? NOP_WORD : imem_rsp_data;
      r_buf_fault[r_wr_ptr] <= imem_rsp_err;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_squash <= 1'b0;
      r_req_pc <= '0;
    end else begin
      if (flush) begin
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        r_count <= w_count_next;
        if (w_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
      end

      // Only one read is ever outstanding, so issuing with a free slot reserves it.
      case (r_state)
        S_IDLE: begin
          if (!flush && (r_count < DEPTH_C)) begin
            r_req_pc <= pc_in;
            r_state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (flush) r_squash <= 1'b1;
          if (imem_req_ready) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (r_squash || flush) begin
              r_squash <= 1'b0;
              r_state  <= S_IDLE;
            end else if (w_count_next < DEPTH_C) begin
              r_req_pc <= pc_in;
              r_state  <= S_REQ;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (flush) begin
            r_squash <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed per-cycle vector bench for instr_fetch, plus hand sequences for
// reset mid-request and flush while idle.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_accept;
  logic        flush;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_fault;
  logic [1:0]  o_dbg_state;

  instr_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .pc_in          (pc_in),
    .pc_accept      (pc_accept),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_fault       (if_fault),
    .o_dbg_state    (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] pc;
    logic        fl, rdy, rv;
    logic [31:0] rd;
    logic        re, ifr;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_acc, e_iv;
    logic [31:0] e_instr, e_ipc;
    logic        e_flt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [31:0] pc, input logic fl, rdy, rv,
                     input logic [31:0] rd, input logic re, ifr,
                     input logic e_rv, input logic [31:0] e_addr,
                     input logic e_acc, e_iv, input logic [31:0] e_instr, e_ipc,
                     input logic e_flt);
    vec_t v;
    v.pc = pc; v.fl = fl; v.rdy = rdy; v.rv = rv; v.rd = rd; v.re = re; v.ifr = ifr;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_acc = e_acc; v.e_iv = e_iv;
    v.e_instr = e_instr; v.e_ipc = e_ipc; v.e_flt = e_flt;
    tbl.push_back(v);
  endtask

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input vec_t v);
    pc_in          = v.pc;
    flush          = v.fl;
    imem_req_ready = v.rdy;
    imem_rsp_valid = v.rv;
    imem_rsp_data  = v.rd;
    imem_rsp_err   = v.re;
    if_ready       = v.ifr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; pc_in = '0; flush = 1'b0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0; if_ready = 1'b0;

    // pc       fl rdy rv data          re ifr | rv addr       acc iv instr         pc        flt
    add(32'h0,   0, 1, 0, 32'h0,        0, 0,    0, 32'h0,     0, 0, 32'h0,        32'h0,    0);
    add(32'h0,   0, 1, 0, 32'h0,        0, 0,    1, 32'h0,     1, 0, 32'h0,        32'h0,    0);
    add(32'h4,   0, 1, 1, 32'h00500093, 0, 0,    0, 32'h0,     0, 0, 32'h0,        32'h0,    0);
    add(32'h4,   0, 1, 0, 32'h0,        0, 0,    1, 32'h4,     1, 1, 32'h00500093, 32'h0,    0);
    add(32'h8,   0, 1, 1, 32'h00400113, 0, 0,    0, 32'h4,     0, 1, 32'h00500093, 32'h0,    0);
    add(32'h8,   0, 1, 0, 32'h0,        0, 0,    0, 32'h4,     0, 1, 32'h00500093, 32'h0,    0);
    add(32'h8,   0, 1, 0, 32'h0,        0, 0,    0, 32'h4,     0, 1, 32'h00500093, 32'h0,    0);
    add(32'h8,   0, 1, 0, 32'h0,        0, 1,    0, 32'h4,     0, 1, 32'h00500093, 32'h0,    0);
    add(32'h8,   0, 1, 0, 32'h0,        0, 0,    0, 32'h4,     0, 1, 32'h00400113, 32'h4,    0);
    add(32'h8,   0, 1, 0, 32'h0,        0, 0,    1, 32'h8,     1, 1, 32'h00400113, 32'h4,    0);
    add(32'hC,   0, 1, 1, 32'h00000033, 0, 1,    0, 32'h8,     0, 1, 32'h00400113, 32'h4,    0);
    add(32'hC,   0, 1, 0, 32'h0,        0, 1,    1, 32'hC,     1, 1, 32'h00000033, 32'h8,    0);
    add(32'h10,  0, 1, 1, 32'h00a00193, 0, 0,    0, 32'hC,     0, 0, 32'h0,        32'h0,    0);
    add(32'h10,  0, 0, 0, 32'h0,        0, 0,    1, 32'h10,    0, 1, 32'h00a00193, 32'hC,    0);
    add(32'h10,  0, 0, 0, 32'h0,        0, 0,    1, 32'h10,    0, 1, 32'h00a00193, 32'hC,    0);
    add(32'h10,  0, 0, 0, 32'h0,        0, 0,    1, 32'h10,    0, 1, 32'h00a00193, 32'hC,    0);
    add(32'h10,  0, 1, 0, 32'h0,        0, 0,    1, 32'h10,    1, 1, 32'h00a00193, 32'hC,    0);
    add(32'h100, 1, 1, 0, 32'h0,        0, 0,    0, 32'h10,    0, 1, 32'h00a00193, 32'hC,    0);
    add(32'h100, 0, 1, 1, 32'hdeadbeef, 0, 0,    0, 32'h10,    0, 0, 32'h0,        32'h0,    0);
    add(32'h100, 0, 1, 0, 32'h0,        0, 0,    0, 32'h10,    0, 0, 32'h0,        32'h0,    0);
    add(32'h100, 0, 1, 0, 32'h0,        0, 0,    1, 32'h100,   1, 0, 32'h0,        32'h0,    0);
    add(32'h20,  0, 1, 1, 32'h00100073, 0, 0,    0, 32'h100,   0, 0, 32'h0,        32'h0,    0);
    add(32'h20,  0, 1, 0, 32'h0,        0, 1,    1, 32'h20,    1, 1, 32'h00100073, 32'h100,  0);
    add(32'h24,  0, 1, 1, 32'hffffffff, 1, 0,    0, 32'h20,    0, 0, 32'h0,        32'h0,    0);
    add(32'h24,  0, 0, 0, 32'h0,        0, 0,    1, 32'h24,    0, 1, 32'h00000013, 32'h20,   1);
    add(32'h24,  1, 1, 0, 32'h0,        0, 0,    1, 32'h24,    0, 1, 32'h00000013, 32'h20,   1);
    add(32'h200, 0, 1, 1, 32'h11111111, 0, 0,    0, 32'h24,    0, 0, 32'h0,        32'h0,    0);
    add(32'h200, 0, 1, 0, 32'h0,        0, 0,    0, 32'h24,    0, 0, 32'h0,        32'h0,    0);
    add(32'h200, 0, 0, 0, 32'h0,        0, 0,    1, 32'h200,   0, 0, 32'h0,        32'h0,    0);

    // Words decode should see, in order.
    exp_q.push_back(32'h00500093);
    exp_q.push_back(32'h00400113);
    exp_q.push_back(32'h00000033);
    exp_q.push_back(32'h00100073);

    // Reset state while held.
    #1;
    chk("rst_req_valid", -1, 32'(imem_req_valid), 32'h0);
    chk("rst_pc_accept", -1, 32'(pc_accept),      32'h0);
    chk("rst_if_valid",  -1, 32'(if_valid),       32'h0);
    chk("rst_if_fault",  -1, 32'(if_fault),       32'h0);
    chk("rst_req_addr",  -1, imem_req_addr,       32'h0);
    chk("rst_if_instr",  -1, if_instr,            32'h0);
    chk("rst_if_pc",     -1, if_pc,               32'h0);
    chk("rst_state",     -1, 32'(o_dbg_state),    32'h0);

    next_cycle();
    next_cycle();
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      #1;
      chk("req_valid", i, 32'(imem_req_valid), 32'(tbl[i].e_rv));
      chk("req_addr",  i, imem_req_addr,       tbl[i].e_addr);
      chk("pc_accept", i, 32'(pc_accept),      32'(tbl[i].e_acc));
      chk("if_valid",  i, 32'(if_valid),       32'(tbl[i].e_iv));
      if (tbl[i].e_iv) begin
        chk("if_instr", i, if_instr,        tbl[i].e_instr);
        chk("if_pc",    i, if_pc,           tbl[i].e_ipc);
        chk("if_fault", i, 32'(if_fault),   32'(tbl[i].e_flt));
      end
      if (if_valid && if_ready && !flush) begin
        if (exp_q.size() == 0) begin
          chk("deq_unexpected", i, if_instr, 32'hxxxxxxxx);
        end else begin
          chk("deq_order", i, if_instr, exp_q.pop_front());
        end
      end
      next_cycle();
    end
    chk("deq_all_seen", 99, 32'(exp_q.size()), 32'h0);

    // Reset mid-request: outputs drop before any clock edge.
    chk("pre_rst_req_valid", 100, 32'(imem_req_valid), 32'h1);
    reset = 1'b0;
    #1;
    chk("async_rst_req_valid", 100, 32'(imem_req_valid), 32'h0);
    chk("async_rst_if_valid",  100, 32'(if_valid),       32'h0);
    chk("async_rst_req_addr",  100, imem_req_addr,       32'h0);
    chk("async_rst_state",     100, 32'(o_dbg_state),    32'h0);

    // Flush while idle holds off issue for that cycle.
    next_cycle();
    pc_in = 32'h300; flush = 1'b1; imem_req_ready = 1'b1; if_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
    reset = 1'b1;
    next_cycle();
    chk("flush_idle_state",     101, 32'(o_dbg_state),    32'h0);
    chk("flush_idle_req_valid", 101, 32'(imem_req_valid), 32'h0);
    flush = 1'b0;
    next_cycle();
    chk("post_flush_req_valid", 102, 32'(imem_req_valid), 32'h1);
    chk("post_flush_req_addr",  102, imem_req_addr,       32'h300);
    chk("post_flush_accept",    102, 32'(pc_accept),      32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
